csr_trap: RTL

//  Machine-mode CSR file and trap arbiter sitting beside the MEM stage. It is the producer for ctrl:
//  it classifies the MEM-stage instruction's exception flags and pending interrupts into excepttype_o,
//  and supplies csr_mepc_o and csr_mtvec_o for the redirect. It also holds mstatus/mie/mip/mcause/mepc/

---
 rtl/csr_trap_pkg.sv | 59 +++++
 rtl/csr_trap_mtimer.sv | 38 +++
 rtl/csr_trap.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/csr_trap_pkg.sv
// Shared constants for the machine-mode CSR file and trap arbiter:
// CSR addresses, excepttype codes, mcause codes and register bit positions.
package csr_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MTIME_LO   = 12'h7C0;
  localparam logic [11:0] CSR_MTIME_HI   = 12'h7C1;
  localparam logic [11:0] CSR_MTIMECMP_LO = 12'h7C2;
  localparam logic [11:0] CSR_MTIMECMP_HI = 12'h7C3;

  localparam logic [31:0] EXC_NONE      = 32'h00;
  localparam logic [31:0] EXC_EXT_IRQ   = 32'h01;
  localparam logic [31:0] EXC_TIMER_IRQ = 32'h02;
  localparam logic [31:0] EXC_ECALL     = 32'h08;
  localparam logic [31:0] EXC_ILLEGAL   = 32'h09;
  localparam logic [31:0] EXC_MRET      = 32'h0a;
  localparam logic [31:0] EXC_EBREAK    = 32'h0b;

  localparam logic [3:0] CAUSE_EXT     = 4'd11;
  localparam logic [3:0] CAUSE_TIMER   = 4'd7;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;

  // Positions inside mem_exc_i = {ebreak, mret, illegal, ecall}
  localparam int FLAG_ECALL   = 0;
  localparam int FLAG_ILLEGAL = 1;
  localparam int FLAG_MRET    = 2;
  localparam int FLAG_EBREAK  = 3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
  localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

  function automatic logic [31:0] cause_of(input logic [31:0] exc);
    logic [31:0] c;
    case (exc)
      EXC_EXT_IRQ:   c = {1'b1, 27'b0, CAUSE_EXT};
      EXC_TIMER_IRQ: c = {1'b1, 27'b0, CAUSE_TIMER};
      EXC_ILLEGAL:   c = {28'b0, CAUSE_ILLEGAL};
      EXC_ECALL:     c = {28'b0, CAUSE_ECALL};
      EXC_EBREAK:    c = {28'b0, CAUSE_EBREAK};
      default:       c = 32'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/csr_trap_mtimer.sv
// Free-running 64-bit mtime with mtimecmp and its compare; both are
// written in 32-bit halves from the WB-stage CSR write port.
module csr_trap_mtimer
  import csr_trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= 64'h0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      // A half-write replaces the count outright; it does not also tick.
      if (we && waddr == CSR_MTIME_LO)
        mtime <= {mtime[63:32], wdata};
      else if (we && waddr == CSR_MTIME_HI)
        mtime <= {wdata, mtime[31:0]};
      else
        mtime <= mtime + 64'd1;

      if (we && waddr == CSR_MTIMECMP_LO)
        mtimecmp <= {mtimecmp[63:32], wdata};
      else if (we && waddr == CSR_MTIMECMP_HI)
        mtimecmp <= {wdata, mtimecmp[31:0]};
    end
  end

  assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/csr_trap.sv
// Machine-mode CSR file and trap arbiter beside MEM: classifies exceptions and
// interrupts for ctrl, commits traps, and serves EX reads with WB forwarding.
module csr_trap
  import csr_trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic [3:0]  mem_exc_i,
  input  logic        irq_ext_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mtvec_o
);

  logic [SYNC_STAGES-1:0] irq_sync;
  logic        meip;
  logic        mstatus_mie, mstatus_mpie;
  logic [1:0]  mstatus_mpp;
  logic        mie_mtie, mie_meie;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mtime, mtimecmp;
  logic        mtip;
  logic        trap_take, trap_mret;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic [31:0] mstatus_rd, rd_val, wr_val;
  logic        fwd_ok;

  csr_trap_mtimer u_mtimer (
    .clk      (clk),
    .rst      (rst),
    .we       (csr_we_i),
    .waddr    (csr_waddr_i),
    .wdata    (csr_wdata_i),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_sync <= '0;
    else     irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_ext_i};
  end
  assign meip = irq_sync[SYNC_STAGES-1];

  always_comb begin
    excepttype_o = EXC_NONE;
    if (mem_valid_i) begin
      if (meip && mie_meie && mstatus_mie)      excepttype_o = EXC_EXT_IRQ;
      else if (mtip && mie_mtie && mstatus_mie) excepttype_o = EXC_TIMER_IRQ;
      else if (mem_exc_i[FLAG_ILLEGAL])         excepttype_o = EXC_ILLEGAL;
      else if (mem_exc_i[FLAG_ECALL])           excepttype_o = EXC_ECALL;
      else if (mem_exc_i[FLAG_EBREAK])          excepttype_o = EXC_EBREAK;
      else if (mem_exc_i[FLAG_MRET])            excepttype_o = EXC_MRET;
    end
  end

  assign trap_mret = (excepttype_o == EXC_MRET);
  assign trap_take = (excepttype_o != EXC_NONE) && !trap_mret;

  assign wr_mstatus  = csr_we_i && csr_waddr_i == CSR_MSTATUS;
  assign wr_mie      = csr_we_i && csr_waddr_i == CSR_MIE;
  assign wr_mtvec    = csr_we_i && csr_waddr_i == CSR_MTVEC;
  assign wr_mscratch = csr_we_i && csr_waddr_i == CSR_MSCRATCH;
  assign wr_mepc     = csr_we_i && csr_waddr_i == CSR_MEPC;
  assign wr_mcause   = csr_we_i && csr_waddr_i == CSR_MCAUSE;

  // Trap side effects take precedence over a WB write to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mstatus_mpp  <= 2'b00;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RST;
      mscratch     <= 32'h0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
    end else begin
      if (trap_take) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (trap_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie  <= csr_wdata_i[MSTATUS_MIE];
        mstatus_mpie <= csr_wdata_i[MSTATUS_MPIE];
        mstatus_mpp  <= csr_wdata_i[MSTATUS_MPP+1:MSTATUS_MPP];
      end

      if (trap_take)    mepc   <= mem_pc_i;
      else if (wr_mepc) mepc   <= csr_wdata_i;

      if (trap_take)      mcause <= cause_of(excepttype_o);
      else if (wr_mcause) mcause <= csr_wdata_i;

      if (wr_mie) begin
        mie_mtie <= csr_wdata_i[MIE_MTIE];
        mie_meie <= csr_wdata_i[MIE_MEIE];
      end
      if (wr_mtvec)    mtvec    <= {csr_wdata_i[31:2], 2'b00};
      if (wr_mscratch) mscratch <= csr_wdata_i;
    end
  end

  always_comb begin
    mstatus_rd = 32'h0;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_rd[MSTATUS_MPP+1:MSTATUS_MPP] = mstatus_mpp;
  end

  always_comb begin
    rd_val = 32'h0;
    case (csr_raddr_i)
      CSR_MSTATUS:     rd_val = mstatus_rd;
      CSR_MIE: begin
        rd_val[MIE_MTIE] = mie_mtie;
        rd_val[MIE_MEIE] = mie_meie;
      end
      CSR_MTVEC:       rd_val = mtvec;
      CSR_MSCRATCH:    rd_val = mscratch;
      CSR_MEPC:        rd_val = mepc;
      CSR_MCAUSE:      rd_val = mcause;
      CSR_MIP: begin
        rd_val[MIE_MTIE] = mtip;
        rd_val[MIE_MEIE] = meip;
      end
      CSR_MTIME_LO:    rd_val = mtime[31:0];
      CSR_MTIME_HI:    rd_val = mtime[63:32];
      CSR_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      CSR_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      default:         rd_val = 32'h0;
    endcase
  end

  // Forwarded value is what the register will hold after the write (mip is read-only).
  always_comb begin
    wr_val = csr_wdata_i;
    fwd_ok = 1'b0;
    case (csr_waddr_i)
      CSR_MSTATUS: begin wr_val = csr_wdata_i & MSTATUS_MASK; fwd_ok = 1'b1; end
      CSR_MIE:     begin wr_val = csr_wdata_i & MIE_MASK;     fwd_ok = 1'b1; end
      CSR_MTVEC:   begin wr_val = {csr_wdata_i[31:2], 2'b00}; fwd_ok = 1'b1; end
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTIME_LO, CSR_MTIME_HI, CSR_MTIMECMP_LO, CSR_MTIMECMP_HI: fwd_ok = 1'b1;
      default:     fwd_ok = 1'b0;
    endcase
  end

  assign csr_rdata_o = (csr_we_i && fwd_ok && csr_waddr_i == csr_raddr_i) ? wr_val : rd_val;
  assign csr_mepc_o  = wr_mepc  ? csr_wdata_i : mepc;
  assign csr_mtvec_o = wr_mtvec ? {csr_wdata_i[31:2], 2'b00} : mtvec;

endmodule
